// File: rtl/tone_event_queue.sv
// ---------------------------------------------------------------------------
// tone_event_queue
//
// Buffers vend/error tone requests in a small FIFO and replays them one at a
// time toward the square-wave tone generator. Each replay is a single-cycle
// vend_event or error_event pulse. item_select is held stable between pulses.
// Replays are spaced by a full tone plus a silent gap, so a queued request
// never retriggers a tone that is still sounding.
//
// Parameters:
//   CLOCK_HZ  system clock frequency
//   TONE_MS   tone length (must match the generator)
//   GAP_MS    silence between queued tones (0 allowed)
//   DEPTH     FIFO entries, power of two, >= 2
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   vend_req     in   one-cycle vend request for item_req
//   error_req    in   one-cycle error request (wins over vend_req)
//   item_req     in   item index sampled with vend_req
//   vend_event   out  one-cycle pulse to the generator
//   error_event  out  one-cycle pulse to the generator
//   item_select  out  item of the current/last tone
//   busy         out  high whenever the sequencer is not idle
//   queue_count  out  entries currently buffered
//   drop_count   out  saturating count of discarded requests
//
// Optional feature: define TONE_QUEUE_COALESCE_EN to absorb a request that
// is identical to the current tail entry instead of enqueuing it again.
// ---------------------------------------------------------------------------
module tone_event_queue #(
    parameter int CLOCK_HZ = 100_000_000,
    parameter int TONE_MS  = 150,
    parameter int GAP_MS   = 20,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vend_req,
    input  logic                     error_req,
    input  logic [1:0]               item_req,
    output logic                     vend_event,
    output logic                     error_event,
    output logic [1:0]               item_select,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [7:0]               drop_count
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] TONE_CYCLES = 32'((CLOCK_HZ / 1000) * TONE_MS);
    localparam logic [31:0] GAP_CYCLES  = 32'((CLOCK_HZ / 1000) * GAP_MS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]     mem_q [DEPTH];
    logic           vend_event_q, vend_event_d;
    logic           error_event_q, error_event_d;
    logic [1:0]     item_q, item_d;
    logic           busy_q, busy_d;
    logic [7:0]     drop_q, drop_d;

    logic [AW:0]    count_s;
    logic           empty_s;
    logic [2:0]     head_s;
    logic [2:0]     tail_s;
    logic           pop_s;
    logic           req_valid_s;
    logic [2:0]     req_entry_s;
    logic           conflict_s;
    logic           room_s;
    logic           absorb_s;
    logic           push_s;
    logic           full_drop_s;
    logic [1:0]     drop_inc_s;
    logic [8:0]     drop_sum_s;

    // FIFO status, request resolution and drop accounting
    always_comb begin
        count_s     = wr_ptr_q - rd_ptr_q;
        empty_s     = (count_s == {(AW + 1){1'b0}});
        head_s      = mem_q[rd_ptr_q[AW-1:0]];
        tail_s      = mem_q[wr_ptr_q[AW-1:0] - AW'(1)];
        pop_s       = (state_q == ST_IDLE) && !empty_s;
        req_valid_s = vend_req | error_req;
        // Error entries always carry item 0; an error beats a same-cycle vend.
        req_entry_s = error_req ? 3'b100 : {1'b0, item_req};
        conflict_s  = vend_req & error_req;
        // A full FIFO still accepts when the head leaves on the same edge.
        room_s      = (count_s < (AW + 1)'(DEPTH)) || pop_s;
`ifdef TONE_QUEUE_COALESCE_EN
        absorb_s    = req_valid_s && !empty_s && (tail_s == req_entry_s);
`else
        absorb_s    = 1'b0;
`endif
        push_s      = req_valid_s && !absorb_s && room_s;
        full_drop_s = req_valid_s && !absorb_s && !room_s;
        drop_inc_s  = {1'b0, conflict_s} + {1'b0, full_drop_s};
        drop_sum_s  = {1'b0, drop_q} + {7'd0, drop_inc_s};
        if (drop_sum_s[8]) begin
            drop_d = 8'hFF;
        end else begin
            drop_d = drop_sum_s[7:0];
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
    end

    // Sequencer next state; counters load terminal-count minus one on entry
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        vend_event_d  = 1'b0;
        error_event_d = 1'b0;
        item_d        = item_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d       = ST_FIRE;
                    vend_event_d  = !head_s[2];
                    error_event_d = head_s[2];
                    item_d        = head_s[1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                state_d = ST_PLAY;
                cnt_d   = TONE_CYCLES - 32'd1;
            end
            ST_PLAY: begin
                if (cnt_q == 32'd0) begin
                    if (GAP_CYCLES == 32'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_CYCLES - 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 32'd0;
            wr_ptr_q      <= {(AW + 1){1'b0}};
            rd_ptr_q      <= {(AW + 1){1'b0}};
            vend_event_q  <= 1'b0;
            error_event_q <= 1'b0;
            item_q        <= 2'd0;
            busy_q        <= 1'b0;
            drop_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            vend_event_q  <= vend_event_d;
            error_event_q <= error_event_d;
            item_q        <= item_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= req_entry_s;
        end
    end

    assign vend_event  = vend_event_q;
    assign error_event = error_event_q;
    assign item_select = item_q;
    assign busy        = busy_q;
    assign queue_count = count_s;
    assign drop_count  = drop_q;

endmodule
